// File: rtl/icache.sv
// Direct-mapped instruction cache between the fetch stage and the memory controller.
// A miss requests one whole line from the memory controller. The filled line is
// never forwarded to fetch; the fetch stage re-issues its request and then hits.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | accepting lookups; a hit answers one cycle later
// FILL  | line request outstanding; mc_en/mc_pc held until mc_done
module icache #(
    parameter int LINE_BYTES = 16,
    parameter int LINES      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic                    fetch_en,
    input  logic [31:0]             fetch_pc,
    output logic                    fetch_done,
    output logic [31:0]             fetch_inst,
    output logic                    mc_en,
    output logic [31:0]             mc_pc,
    input  logic                    mc_done,
    input  logic [8*LINE_BYTES-1:0] mc_data
);

    localparam int OFF_BITS  = $clog2(LINE_BYTES);
    localparam int WORD_BITS = OFF_BITS - 2;
    localparam int IDX_BITS  = $clog2(LINES);
    localparam int TAG_BITS  = 32 - OFF_BITS - IDX_BITS;
    localparam int LINE_W    = 8 * LINE_BYTES;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t               state;
    logic [LINES-1:0]     valid;
    logic [TAG_BITS-1:0]  tag_mem  [LINES];
    logic [LINE_W-1:0]    data_mem [LINES];

    // Index and tag of the outstanding miss, so fetch_pc may wander during FILL.
    logic [IDX_BITS-1:0]  fill_idx;
    logic [TAG_BITS-1:0]  fill_tag;

    logic [IDX_BITS-1:0]  req_idx;
    logic [TAG_BITS-1:0]  req_tag;
    logic [WORD_BITS-1:0] req_word;
    logic [LINE_W-1:0]    line_rd;
    logic [31:0]          word_rd;
    logic                 hit;
    logic                 lookup;
    logic                 fill_commit;
    logic                 unused_pc_bits;

    // Split the request address into index, tag and word select.
    assign req_idx        = fetch_pc[OFF_BITS +: IDX_BITS];
    assign req_tag        = fetch_pc[31 -: TAG_BITS];
    assign req_word       = fetch_pc[2 +: WORD_BITS];
    assign unused_pc_bits = ^fetch_pc[1:0];

    // Read the indexed line and pick out the requested word.
    assign line_rd = data_mem[req_idx];
    assign word_rd = line_rd[{req_word, 5'd0} +: 32];
    assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    // A lookup is skipped during a flush and in the cycle fetch_done is high.
    assign lookup      = (state == IDLE) && fetch_en && !rollback && !fetch_done;
    assign fill_commit = (state == FILL) && mc_done;

    // Controller: lookup/miss handling, fill tracking, valid bits and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            fetch_done <= 1'b0;
            fetch_inst <= '0;
            mc_en      <= 1'b0;
            mc_pc      <= '0;
            fill_idx   <= '0;
            fill_tag   <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    fetch_done <= 1'b0;
                    if (lookup) begin
                        if (hit) begin
                            fetch_done <= 1'b1;
                            fetch_inst <= word_rd;
                        end else begin
                            state    <= FILL;
                            mc_en    <= 1'b1;
                            mc_pc    <= {fetch_pc[31:OFF_BITS], {OFF_BITS{1'b0}}};
                            fill_idx <= req_idx;
                            fill_tag <= req_tag;
                        end
                    end
                end
                FILL: begin
                    // A flush here is deliberately ignored: the burst cannot be aborted.
                    if (mc_done) begin
                        valid[fill_idx] <= 1'b1;
                        mc_en           <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage: written only when a fill completes; contents are don't-care until valid.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_commit) begin
            data_mem[fill_idx] <= mc_data;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by randomized
// fetches, all compared against a line-level reference model of the cache.
module tb_icache;

    logic         clk;
    logic         rst;
    logic         rdy;
    logic         rollback;
    logic         fetch_en;
    logic [31:0]  fetch_pc;
    logic         fetch_done;
    logic [31:0]  fetch_inst;
    logic         mc_en;
    logic [31:0]  mc_pc;
    logic         mc_done;
    logic [127:0] mc_data;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per index, whether it holds a line, which line address, and its bytes.
    bit           m_valid [16];
    logic [31:0]  m_addr  [16];
    logic [127:0] m_data  [16];

    icache #(.LINE_BYTES(16), .LINES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .rollback   (rollback),
        .fetch_en   (fetch_en),
        .fetch_pc   (fetch_pc),
        .fetch_done (fetch_done),
        .fetch_inst (fetch_inst),
        .mc_en      (mc_en),
        .mc_pc      (mc_pc),
        .mc_done    (mc_done),
        .mc_data    (mc_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 16) % 16);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_addr[idx_of(pc)] == (pc & ~32'hF));
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] pc);
        logic [127:0] l;
        l = m_data[idx_of(pc)] >> (32 * ((pc / 4) % 4));
        return l[31:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // Fetch expected to hit: answer one cycle later, a single-cycle pulse, no memory request.
    task automatic hit_fetch(input logic [31:0] pc);
        fetch_en = 1'b1;
        fetch_pc = pc;
        step();
        check("hit_done", 32'(fetch_done), 32'd1);
        check("hit_inst", fetch_inst, model_word(pc));
        check("hit_no_mc", 32'(mc_en), 32'd0);
        step();
        check("done_pulse", 32'(fetch_done), 32'd0);
        fetch_en = 1'b0;
    endtask

    // Fetch expected to miss: line request, held through memory delay, then the line lands.
    task automatic miss_fill(input logic [31:0] pc, input logic [127:0] line,
                             input bit rb_mid, input int delay);
        logic [31:0] la;
        la = pc & ~32'hF;
        fetch_en = 1'b1;
        fetch_pc = pc;
        step();
        check("miss_mc_en", 32'(mc_en), 32'd1);
        check("miss_mc_pc", mc_pc, la);
        check("miss_no_done", 32'(fetch_done), 32'd0);
        fetch_pc = $urandom;
        fetch_en = 1'($urandom_range(0, 1));
        for (int i = 0; i < delay; i++) begin
            rollback = rb_mid && (i == 0);
            step();
            rollback = 1'b0;
            check("fill_mc_en", 32'(mc_en), 32'd1);
            check("fill_mc_pc", mc_pc, la);
        end
        mc_done  = 1'b1;
        mc_data  = line;
        fetch_en = 1'b0;
        step();
        mc_done = 1'b0;
        mc_data = {4{$urandom}};
        check("fill_end_mc_en", 32'(mc_en), 32'd0);
        check("fill_end_no_done", 32'(fetch_done), 32'd0);
        m_valid[idx_of(pc)] = 1'b1;
        m_addr[idx_of(pc)]  = la;
        m_data[idx_of(pc)]  = line;
        step();
        check("fill_no_forward", 32'(fetch_done), 32'd0);
    endtask

    task automatic fetch_any(input logic [31:0] pc);
        bit rb;
        if (model_hit(pc)) begin
            hit_fetch(pc);
        end else begin
            rb = ($urandom_range(0, 3) == 0);
            miss_fill(pc, {$urandom, $urandom, $urandom, $urandom}, rb,
                      rb ? int'($urandom_range(1, 5)) : int'($urandom_range(0, 5)));
            hit_fetch(pc);
        end
    endtask

    initial begin
        logic [31:0] pc;
        rst      = 1'b1;
        rdy      = 1'b1;
        rollback = 1'b0;
        fetch_en = 1'b0;
        fetch_pc = '0;
        mc_done  = 1'b0;
        mc_data  = '0;
        model_clear();
        step();
        step();
        rst = 1'b0;
        check("rst_done", 32'(fetch_done), 32'd0);
        check("rst_inst", fetch_inst, 32'd0);
        check("rst_mc_en", 32'(mc_en), 32'd0);
        check("rst_mc_pc", mc_pc, 32'd0);

        // Cold miss, then hits in the same line.
        miss_fill(32'h0000_1004, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0, 2);
        hit_fetch(32'h0000_1004);
        check("cold_inst", fetch_inst, 32'h0706_0504);
        hit_fetch(32'h0000_100C);
        check("hit_inst_c", fetch_inst, 32'h0F0E_0D0C);

        // Conflict on index 0 evicts the first line.
        miss_fill(32'h0000_1104, {4{$urandom}}, 1'b0, 1);
        hit_fetch(32'h0000_1104);
        miss_fill(32'h0000_1004, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0, 3);
        hit_fetch(32'h0000_1000);
        check("refill_inst", fetch_inst, 32'h0302_0100);

        // Flush in IDLE kills both a hit and a miss lookup.
        rollback = 1'b1;
        fetch_en = 1'b1;
        fetch_pc = 32'h0000_1004;
        step();
        check("rb_hit_done", 32'(fetch_done), 32'd0);
        fetch_pc = 32'h0000_2000;
        step();
        check("rb_miss_mc_en", 32'(mc_en), 32'd0);
        rollback = 1'b0;
        fetch_en = 1'b0;

        // Flush in FILL: the fill still completes and the line hits afterwards.
        miss_fill(32'h0000_3008, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 3);
        hit_fetch(32'h0000_3008);

        // Stall for three cycles during a hit lookup, then stall while fetch_done is high.
        rdy      = 1'b0;
        fetch_en = 1'b1;
        fetch_pc = 32'h0000_3008;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_done", 32'(fetch_done), 32'd0);
        end
        rdy = 1'b1;
        step();
        check("stall_hit_done", 32'(fetch_done), 32'd1);
        check("stall_hit_inst", fetch_inst, model_word(32'h0000_3008));
        rdy = 1'b0;
        step();
        check("stall_hold_done", 32'(fetch_done), 32'd1);
        check("stall_hold_inst", fetch_inst, model_word(32'h0000_3008));
        rdy      = 1'b1;
        fetch_en = 1'b0;
        step();
        check("stall_release", 32'(fetch_done), 32'd0);

        // Stray mc_done in IDLE changes nothing.
        mc_done = 1'b1;
        mc_data = {4{32'hDEAD_BEEF}};
        step();
        mc_done = 1'b0;
        check("stray_mc_en", 32'(mc_en), 32'd0);
        hit_fetch(32'h0000_3008);

        // Reset during FILL abandons the fill; the late mc_done is ignored.
        fetch_en = 1'b1;
        fetch_pc = 32'h0000_4000;
        step();
        check("rfill_mc_en", 32'(mc_en), 32'd1);
        fetch_en = 1'b0;
        rst      = 1'b1;
        rdy      = 1'b0;
        step();
        rst = 1'b0;
        rdy = 1'b1;
        check("rfill_rst_mc_en", 32'(mc_en), 32'd0);
        check("rfill_rst_mc_pc", mc_pc, 32'd0);
        check("rfill_rst_inst", fetch_inst, 32'd0);
        model_clear();
        mc_done = 1'b1;
        mc_data = {4{32'h1234_5678}};
        step();
        mc_done = 1'b0;
        check("rfill_late_mc_en", 32'(mc_en), 32'd0);
        miss_fill(32'h0000_4000, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 2);
        hit_fetch(32'h0000_4000);
        miss_fill(32'h0000_3008, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0);
        hit_fetch(32'h0000_3008);

        // Randomized traffic over a small address pool to mix hits, misses and conflicts.
        for (int n = 0; n < 80; n++) begin
            pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
               | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 7) == 0) pc = pc | 32'hA000_0000;
            fetch_any(pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 16, bytes per cache line; equals the memory controller's per-fetch burst length.
REQ-002 SHALL have parameter LINES, default 16, number of direct-mapped lines.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rdy  input  1  global enable; when low, all state and outputs hold.
REQ-006 rollback  input  1  pipeline flush from the commit stage.
REQ-007 fetch_en  input  1  instruction fetch request from the fetch stage.
REQ-008 fetch_pc  input  32  byte address of the requested instruction, 4-byte aligned.
REQ-009 fetch_done  output  1  registered one-cycle pulse: fetch_inst valid.
REQ-010 fetch_inst  output  32  instruction word for the accepted fetch_pc.
REQ-011 mc_en  output  1  line-fill request to the memory controller.
REQ-012 mc_pc  output  32  line-aligned fill address.
REQ-013 mc_done  input  1  one-cycle pulse: mc_data holds the full line.
REQ-014 mc_data  input  8*LINE_BYTES  line data, byte i at bits [8i+7:8i].

Function
REQ-015 SHALL decompose the address (defaults): offset = pc[3:2] word select, index = pc[7:4], tag = pc[31:8].
REQ-016 SHALL store per line a valid bit, a 24-bit tag and 128 data bits.
REQ-017 SHALL implement states IDLE and FILL.
REQ-018 In IDLE, with fetch_en=1, rollback=0 and fetch_done=0: hit (valid and tag match) -> next cycle fetch_done=1, fetch_inst = selected word, state stays IDLE.
REQ-019 In IDLE on a miss, next cycle: state FILL, mc_en=1, mc_pc = {fetch_pc[31:4],4'b0}; the miss pc is latched internally.
REQ-020 fetch_done SHALL be a one-cycle pulse; the cycle it is high, no new lookup is accepted.
REQ-021 In FILL, mc_en and mc_pc SHALL hold steady until mc_done=1.
REQ-022 On mc_done in FILL: write the line's data and tag, set valid, drop mc_en, and return to IDLE on the next edge.
REQ-023 The line fill SHALL NOT deliver data directly to fetch; the re-issued fetch_en hits in IDLE. Miss latency: 1 + memory time + 2 cycles.
REQ-024 Rollback while in IDLE SHALL suppress any fetch_done scheduled for the next cycle; the lookup in that cycle is ignored.
REQ-025 Rollback in FILL SHALL NOT abort the fill, because the memory controller does not abort instruction bursts. The fill completes and the line becomes valid; no fetch_done follows.
REQ-026 fetch_pc changes while in FILL SHALL be ignored until the return to IDLE.
REQ-027 mc_done outside FILL SHALL be ignored.
REQ-028 With rdy=0, no state, array, or output SHALL change, and fetch_done/mc_en SHALL hold their values.

Reset
REQ-029 On rst=1, the block SHALL: clear all valid bits; set state to IDLE; set fetch_done=0, fetch_inst=0, mc_en=0 and mc_pc=0.
REQ-030 Reset during FILL SHALL abandon the fill, leave the line invalid, and ignore a subsequent stale mc_done.
REQ-031 Reset SHALL take priority over rdy and rollback.

Verification
REQ-032 Cold miss: fetch_pc=0x00001004 after reset -> mc_en=1 with mc_pc=0x00001000. mc_done returns bytes 0x00..0x0F -> second fetch_en yields fetch_done with fetch_inst=0x07060504.
REQ-033 Hit: after REQ-032, fetch_pc=0x0000100C -> fetch_done 1 cycle later with fetch_inst=0x0F0E0D0C, mc_en stays 0.
REQ-034 Conflict: fetch_pc=0x00001104 (same index 0, tag differs) -> miss, refill at 0x00001100. After that, 0x00001004 misses again.
REQ-035 Rollback in FILL: rollback pulsed mid-fill -> fill completes, line valid, no fetch_done. A later fetch of the same pc hits with no mc_en.
REQ-036 rdy=0 for 3 cycles during hit lookup -> fetch_done delayed by 3 cycles, fetch_inst value unchanged.
REQ-037 Reset mid-FILL: rst asserted while mc_en=1 -> mc_en=0 next cycle, a late mc_done is ignored, and the next fetch of that pc misses.
